// File: rtl/score_keeper.sv
// score_keeper: turns lane button presses and note-zone status into score, combo,
// multiplier and per-lane hit flashes for the screen generator.
module score_keeper #(
    parameter int POINTS_PER_HIT = 10,
    parameter int SCORE_MAX      = 99999,
    parameter int COMBO_STEP     = 10,
    parameter int MULT_MAX       = 4,
    parameter int FLASH_FRAMES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  btn,
    input  logic [4:0]  note_in_zone,
    input  logic [4:0]  note_missed,
    input  logic        frame_tick,
    input  logic        game_start,
    input  logic        game_end,
    output logic [16:0] score,
    output logic [6:0]  combo,
    output logic [2:0]  multiplier,
    output logic [4:0]  hit_flash,
    output logic        game_active
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    state_t state, state_next;

    logic [4:0]    s1, s2, prev, press, hit, wrong;
    logic          miss;
    logic [2:0]    h;
    logic [17:0]   score_sum;
    logic [16:0]   score_next;
    logic [7:0]    combo_sum;
    logic [6:0]    combo_next, step;
    logic [2:0]    mult_next;
    logic [FW-1:0] flash [5];

    always_comb begin
        state_next = game_start ? PLAY : (state == PLAY && game_end) ? OVER : state;
        press      = s2 & ~prev;
        hit        = (state == PLAY) ? (press & note_in_zone) : 5'd0;
        wrong      = (state == PLAY) ? (press & ~note_in_zone) : 5'd0;
        miss       = |wrong || |note_missed;
        h          = 3'($countones(hit));
        // the add uses the multiplier from before this edge; 18 bits hold the overshoot
        score_sum  = {1'b0, score} + 18'(h) * 18'(POINTS_PER_HIT) * 18'(multiplier);
        score_next = (score_sum > 18'(SCORE_MAX)) ? 17'(SCORE_MAX) : score_sum[16:0];
        combo_sum  = {1'b0, combo} + 8'(h);
        combo_next = miss ? 7'd0 : (combo_sum > 8'd127) ? 7'd127 : combo_sum[6:0];
        step       = combo_next / 7'(COMBO_STEP);
        mult_next  = (step >= 7'(MULT_MAX - 1)) ? 3'(MULT_MAX) : 3'(step) + 3'd1;
        for (int i = 0; i < 5; i++) hit_flash[i] = (flash[i] != '0);
        game_active = (state == PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            s1         <= '0;
            s2         <= '0;
            prev       <= '0;
            score      <= '0;
            combo      <= '0;
            multiplier <= 3'd1;
            for (int i = 0; i < 5; i++) flash[i] <= '0;
        end else begin
            state <= state_next;
            s1    <= btn;
            s2    <= s1;
            prev  <= s2;
            if (game_start) begin
                score      <= '0;
                combo      <= '0;
                multiplier <= 3'd1;
            end else if (state == PLAY) begin
                score      <= score_next;
                combo      <= combo_next;
                multiplier <= mult_next;
            end
            // a fresh hit reloads the lane even if a frame_tick lands in the same cycle
            for (int i = 0; i < 5; i++)
                flash[i] <= game_start ? '0 :
                            hit[i] ? FW'(FLASH_FRAMES) :
                            (frame_tick && flash[i] != '0) ? flash[i] - 1'b1 : flash[i];
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus against a behavioural game model;
// expected outputs go through a queue to an independent per-cycle monitor.
module tb_score_keeper;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  btn = '0, note_in_zone = '0, note_missed = '0;
    logic        frame_tick = 1'b0, game_start = 1'b0, game_end = 1'b0;
    logic [16:0] score;
    logic [6:0]  combo;
    logic [2:0]  multiplier;
    logic [4:0]  hit_flash;
    logic        game_active;

    typedef struct packed {
        logic [16:0] score;
        logic [6:0]  combo;
        logic [2:0]  mult;
        logic [4:0]  flash;
        logic        active;
    } snap_t;

    snap_t exp_q[$];
    int vectors = 0, miscompares = 0;

    // model state: 0 idle, 1 play, 2 over; hist[k] = btn sampled k+1 edges ago
    int m_state, m_score, m_combo, m_mult;
    int m_flash[5];
    logic [4:0] hist[3];

    score_keeper dut (
        .clk(clk), .reset(reset), .btn(btn), .note_in_zone(note_in_zone),
        .note_missed(note_missed), .frame_tick(frame_tick), .game_start(game_start),
        .game_end(game_end), .score(score), .combo(combo), .multiplier(multiplier),
        .hit_flash(hit_flash), .game_active(game_active)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [4:0] pr, hits, wrongs;
        int n;
        snap_t e;
        if (reset) begin
            m_state = 0; m_score = 0; m_combo = 0; m_mult = 1;
            foreach (m_flash[i]) m_flash[i] = 0;
            foreach (hist[i]) hist[i] = '0;
        end else begin
            // a press is a rising btn seen two edges back versus three edges back
            pr = hist[1] & ~hist[2];
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn;
            hits = (m_state == 1) ? (pr & note_in_zone) : 5'd0;
            wrongs = (m_state == 1) ? (pr & ~note_in_zone) : 5'd0;
            if (game_start) begin
                m_state = 1; m_score = 0; m_combo = 0; m_mult = 1;
                foreach (m_flash[i]) m_flash[i] = 0;
            end else begin
                if (m_state == 1) begin
                    n = $countones(hits);
                    m_score = m_score + n * 10 * m_mult;
                    if (m_score > 99999) m_score = 99999;
                    if (wrongs != 0 || note_missed != 0) m_combo = 0;
                    else m_combo = (m_combo + n > 127) ? 127 : m_combo + n;
                    m_mult = (1 + m_combo / 10 > 4) ? 4 : 1 + m_combo / 10;
                    if (game_end) m_state = 2;
                end
                foreach (m_flash[i])
                    if (hits[i]) m_flash[i] = 8;
                    else if (frame_tick && m_flash[i] > 0) m_flash[i]--;
            end
        end
        e.score = 17'(m_score);
        e.combo = 7'(m_combo);
        e.mult = 3'(m_mult);
        foreach (m_flash[i]) e.flash[i] = (m_flash[i] != 0);
        e.active = (m_state == 1);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [4:0] b, z, m, input logic f, s, e, r);
        @(negedge clk);
        btn = b; note_in_zone = z; note_missed = m;
        frame_tick = f; game_start = s; game_end = e; reset = r;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{score, combo, multiplier, hit_flash, game_active};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got score=%0d combo=%0d mult=%0d flash=%b active=%b, expected score=%0d combo=%0d mult=%0d flash=%b active=%b",
                             $time, a.score, a.combo, a.mult, a.flash, a.active,
                             e.score, e.combo, e.mult, e.flash, e.active);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++)
            cyc(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(5'b00001, 5'b00001, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 5'b00001, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        // combo ramp through multiplier steps, with hits and a miss in one cycle
        for (int i = 0; i < 24; i++) cyc((i % 2) ? 5'b00100 : 5'b0, 5'b11111, 0, 0, 0, 0, 0);
        cyc(5'b01010, 5'b11111, 0, 0, 0, 0, 0);
        cyc(0, 5'b11111, 0, 0, 0, 0, 0);
        cyc(0, 5'b11111, 5'b10000, 0, 0, 0, 0);
        cyc(0, 5'b11111, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            cyc(5'($urandom), 5'($urandom), ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'd0,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 99) == 0), 1'b0);
        // all lanes hitting every other cycle drives score and combo into saturation
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 1200; i++)
            cyc((i % 2) ? 5'b11111 : 5'b0, 5'b11111, 0, ($urandom_range(0, 7) == 0), 0, 0, 0);
        cyc(0, 5'b11111, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc((i % 2) ? 5'b11111 : 5'b0, 5'b11111, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc((i % 2) ? 5'b00011 : 5'b0, 5'b00011, 0, 0, 0, 0, 0);
        cyc(5'b11111, 5'b11111, 5'b11111, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) cyc(5'($urandom), 5'($urandom), 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
